// File: rtl/fp_pkg.sv
// fp_pkg: shared constants and helpers for the floating-point normalise/round path.
//   - Rounding-mode encodings (RM_*), matching the 2-bit in_rm port.
//   - Bit positions of the {overflow, underflow, inexact} flag vector.
//   - fp32 default field widths.
//   - round_inc(): rounding increment decision from mode, sign and L/G/R/S.
package fp_pkg;

    localparam logic [1:0] RM_RNE = 2'd0;   // round to nearest, ties to even
    localparam logic [1:0] RM_RTZ = 2'd1;   // round toward zero
    localparam logic [1:0] RM_RUP = 2'd2;   // round toward +inf
    localparam logic [1:0] RM_RDN = 2'd3;   // round toward -inf

    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_NX  = 0;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;

    // Decide whether one unit in the last place is added to the significand.
    function automatic logic round_inc(
        input logic [1:0] rm,
        input logic       sign,
        input logic       lsb,
        input logic       guard,
        input logic       rnd,
        input logic       sticky
    );
        logic inc;
        case (rm)
            RM_RNE:  inc = guard & (rnd | sticky | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~sign & (guard | rnd | sticky);
            default: inc = sign & (guard | rnd | sticky);
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: parametrised log-step leading-zero counter.
//   din      - vector to scan, MSB first.
//   count    - number of zeros above the most significant 1; equals W when din is 0.
//   all_zero - din contains no set bit.
// The input is padded with zeros on the LSB side up to a power of two, then each
// level checks whether the upper half of the current window is zero, records one
// count bit and keeps the half that still holds the leading one. If din is zero
// the final surviving bit is zero, which doubles as the all-zero indication.
module fp_lzc #(
    parameter int W     = 27,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     din,
    output logic [CNT_W-1:0] count,
    output logic             all_zero
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int P  = 1 << CW;

    logic [P-1:0]  padded;
    logic [CW-1:0] cnt;
    logic          last_bit;

    generate
        if (P > W) begin : g_pad
            assign padded = {din, {(P - W){1'b0}}};
        end else begin : g_nopad
            assign padded = din;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < CW; gi++) begin : g_lvl
            localparam int WW = P >> gi;
            localparam int HW = WW / 2;

            logic [WW-1:0] win;
            logic [HW-1:0] nxt;
            logic          hi_zero;

            if (gi == 0) begin : g_first
                assign win = padded;
            end else begin : g_chain
                assign win = g_lvl[gi-1].nxt;
            end

            assign hi_zero         = ~|win[WW-1:HW];
            assign cnt[CW-1-gi]    = hi_zero;
            assign nxt             = hi_zero ? win[HW-1:0] : win[WW-1:HW];
        end
    endgenerate

    assign last_bit = g_lvl[CW-1].nxt[0];
    assign all_zero = ~last_bit;
    assign count    = all_zero ? CNT_W'(W) : CNT_W'(cnt);

endmodule

// File: rtl/fp_norm_round_pipe.sv
// fp_norm_round_pipe: three-stage normalise-and-round stage of the FP adder.
//   clk, rst             - clock and synchronous active-high reset.
//   in_valid / in_ready  - input handshake.
//   in_sign, in_exp      - result sign and biased pre-normalisation exponent.
//   in_frac              - {carry, hidden, mantissa[MAN_W], guard, round, sticky}.
//   in_rm                - rounding mode (RM_* in fp_pkg).
//   in_tag               - opaque sideband returned with the result.
//   out_valid / out_ready- output handshake.
//   out_result           - {sign, exponent, mantissa}.
//   out_tag, out_flags   - tag and {overflow, underflow, inexact}.
// Stages: S1 registers inputs plus leading-zero count, S2 holds the normalised
// fraction/exponent, S3 holds the packed result. Each stage loads when empty or
// when its content moves on, so bubbles collapse and ready ripples back
// combinationally from out_ready.
module fp_norm_round_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP32_EXP_W,
    parameter int MAN_W = FP32_MAN_W,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [MAN_W+4:0]       in_frac,
    input  logic [1:0]             in_rm,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [2:0]             out_flags
);

    localparam int FW   = MAN_W + 5;          // full input fraction width
    localparam int NW   = FW - 1;             // fraction width without carry
    localparam int LZ_W = $clog2(NW + 1);
    localparam int EW2  = EXP_W + 2;          // signed exponent working width

    localparam logic signed [EW2-1:0] EXP_ONE = {{(EW2-1){1'b0}}, 1'b1};
    localparam logic signed [EW2-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    // ---------------- handshake ----------------
    logic s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic s1_en, s2_en, s3_en;

    assign s3_en    = ~s3_valid_reg | out_ready;
    assign s2_en    = ~s2_valid_reg | s3_en;
    assign s1_en    = ~s1_valid_reg | s2_en;
    assign in_ready = s1_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s3_valid_reg <= 1'b0;
        end else begin
            if (s1_en) s1_valid_reg <= in_valid;
            if (s2_en) s2_valid_reg <= s1_valid_reg;
            if (s3_en) s3_valid_reg <= s2_valid_reg;
        end
    end

    // ---------------- S1: classify ----------------
    logic [LZ_W-1:0] lz_next;
    logic            low_zero;
    logic            s1_zero_next;

    fp_lzc #(
        .W     (NW),
        .CNT_W (LZ_W)
    ) u_lzc (
        .din      (in_frac[NW-1:0]),
        .count    (lz_next),
        .all_zero (low_zero)
    );

    assign s1_zero_next = low_zero & ~in_frac[FW-1];

    logic             s1_sign_reg;
    logic [EXP_W-1:0] s1_exp_reg;
    logic [FW-1:0]    s1_frac_reg;
    logic [1:0]       s1_rm_reg;
    logic [TAG_W-1:0] s1_tag_reg;
    logic [LZ_W-1:0]  s1_lz_reg;
    logic             s1_zero_reg;

    always_ff @(posedge clk) begin
        if (s1_en) begin
            s1_sign_reg <= in_sign;
            s1_exp_reg  <= in_exp;
            s1_frac_reg <= in_frac;
            s1_rm_reg   <= in_rm;
            s1_tag_reg  <= in_tag;
            s1_lz_reg   <= lz_next;
            s1_zero_reg <= s1_zero_next;
        end
    end

    // ---------------- S2: normalise ----------------
    // After normalisation the carry position is always clear, so S2 keeps only
    // {hidden, mantissa, G, R, S}.
    logic signed [EW2-1:0] exp_ext, lz_ext;
    logic [NW-1:0]         s2_frac_next;
    logic signed [EW2-1:0] s2_exp_next;

    assign exp_ext = {2'b00, s1_exp_reg};
    assign lz_ext  = {{(EW2-LZ_W){1'b0}}, s1_lz_reg};

    always_comb begin
        s2_frac_next = '0;
        s2_exp_next  = '0;
        if (s1_zero_reg) begin
            s2_frac_next = '0;
            s2_exp_next  = '0;
        end else if (s1_frac_reg[FW-1]) begin
            // The bit dropped off the bottom folds into sticky.
            s2_frac_next = {s1_frac_reg[FW-1:2], s1_frac_reg[1] | s1_frac_reg[0]};
            s2_exp_next  = exp_ext + EXP_ONE;
        end else begin
            s2_frac_next = s1_frac_reg[NW-1:0] << s1_lz_reg;
            s2_exp_next  = exp_ext - lz_ext;
        end
    end

    logic                  s2_sign_reg;
    logic signed [EW2-1:0] s2_exp_reg;
    logic [NW-1:0]         s2_frac_reg;
    logic [1:0]            s2_rm_reg;
    logic [TAG_W-1:0]      s2_tag_reg;
    logic                  s2_zero_reg;

    always_ff @(posedge clk) begin
        if (s2_en) begin
            s2_sign_reg <= s1_sign_reg;
            s2_exp_reg  <= s2_exp_next;
            s2_frac_reg <= s2_frac_next;
            s2_rm_reg   <= s1_rm_reg;
            s2_tag_reg  <= s1_tag_reg;
            s2_zero_reg <= s1_zero_reg;
        end
    end

    // ---------------- S3: round and pack ----------------
    logic                  g_bit, r_bit, s_bit, l_bit, inc;
    logic [MAN_W+1:0]      sig_sum;
    logic [MAN_W-1:0]      rnd_man;
    logic signed [EW2-1:0] rnd_exp;
    logic                  ovf, unf, inexact;
    logic [EXP_W+MAN_W:0]  s3_result_next;
    logic [2:0]            s3_flags_next;

    assign l_bit = s2_frac_reg[3];
    assign g_bit = s2_frac_reg[2];
    assign r_bit = s2_frac_reg[1];
    assign s_bit = s2_frac_reg[0];

    assign inc     = round_inc(s2_rm_reg, s2_sign_reg, l_bit, g_bit, r_bit, s_bit);
    assign sig_sum = {1'b0, s2_frac_reg[NW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    // A carry out of the significand means it became 10.00..0: renormalise.
    assign rnd_man = sig_sum[MAN_W+1] ? sig_sum[MAN_W:1] : sig_sum[MAN_W-1:0];
    assign rnd_exp = s2_exp_reg + $signed({{(EW2-1){1'b0}}, sig_sum[MAN_W+1]});

    assign inexact = g_bit | r_bit | s_bit;
    assign ovf     = (rnd_exp >= EXP_MAX);
    // Underflow is judged on the normalised exponent, before rounding.
    assign unf     = s2_exp_reg[EW2-1] | (s2_exp_reg == '0);

    always_comb begin
        s3_result_next = {s2_sign_reg, rnd_exp[EXP_W-1:0], rnd_man};
        s3_flags_next  = '0;
        s3_flags_next[FLAG_NX] = inexact;
        if (s2_zero_reg) begin
            s3_result_next = {s2_sign_reg, {(EXP_W+MAN_W){1'b0}}};
            s3_flags_next  = '0;
        end else if (unf) begin
            s3_result_next = {s2_sign_reg, {(EXP_W+MAN_W){1'b0}}};
            s3_flags_next[FLAG_UNF] = 1'b1;
            s3_flags_next[FLAG_NX]  = 1'b1;
        end else if (ovf) begin
            // Saturate to infinity or to the largest finite value depending on
            // whether the mode rounds away from zero for this sign.
            if ((s2_rm_reg == RM_RNE) ||
                (s2_rm_reg == RM_RUP && !s2_sign_reg) ||
                (s2_rm_reg == RM_RDN &&  s2_sign_reg)) begin
                s3_result_next = {s2_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                s3_result_next = {s2_sign_reg, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            end
            s3_flags_next[FLAG_OVF] = 1'b1;
            s3_flags_next[FLAG_NX]  = 1'b1;
        end
    end

    logic [EXP_W+MAN_W:0] s3_result_reg;
    logic [2:0]           s3_flags_reg;
    logic [TAG_W-1:0]     s3_tag_reg;

    always_ff @(posedge clk) begin
        if (s3_en) begin
            s3_result_reg <= s3_result_next;
            s3_flags_reg  <= s3_flags_next;
            s3_tag_reg    <= s2_tag_reg;
        end
    end

    // Data registers are not reset; gating by the valid keeps outputs at zero
    // after reset and when the stage is empty.
    assign out_valid  = s3_valid_reg;
    assign out_result = s3_valid_reg ? s3_result_reg : '0;
    assign out_tag    = s3_valid_reg ? s3_tag_reg    : '0;
    assign out_flags  = s3_valid_reg ? s3_flags_reg  : '0;

endmodule
